// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types and helpers for the sequential binary-to-BCD converter
package bin2bcd_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   // ceil(w * log10(2)) in fixed point; log10(2) ~ 0.30103
   function automatic int digits_for_width(input int w);
      return (w * 30103 + 99999) / 100000;
   endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble correction, adds 3 to a BCD digit of 5 or more
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [3:0] d_i,
   output logic [3:0] d_o
);
   assign d_o = (d_i >= BCD_ADJ_THRESH) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary-to-BCD converter, one input bit per clock
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [WIDTH-1:0]    value_i,
   output logic                ready_o,
   output logic                busy_o,
   output logic                done_o,
   output logic [4*DIGITS-1:0] bcd_o,
   output logic                overflow_o
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int BW = 4 * DIGITS;
   if (DIGITS < 1) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS must be >= 1");
   end
   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  sr_q, sr_d;
   logic [BW-1:0]     wb_q, wb_d;
   logic              sov_q, sov_d;
   logic [BW-1:0]     bcd_q, bcd_d;
   logic              ovf_q, ovf_d;
   logic [BW-1:0]     adj;
   logic [BW:0]       sh;
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (.d_i(wb_q[4*g +: 4]), .d_o(adj[4*g +: 4]));
   end
   // top bit of sh is the carry leaving the highest digit
   assign sh = {adj, sr_q[WIDTH-1]};
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      wb_d    = wb_q;
      sov_d   = sov_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      if (state_q != SHIFT && start_i) begin
         state_d = SHIFT;
         sr_d    = value_i;
         wb_d    = '0;
         sov_d   = 1'b0;
         cnt_d   = '0;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end else if (state_q == SHIFT) begin
         sr_d  = sr_q << 1;
         wb_d  = sh[BW-1:0];
         sov_d = sov_q | sh[BW];
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            bcd_d   = sh[BW-1:0];
            ovf_d   = sov_q | sh[BW];
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         wb_q    <= '0;
         sov_q   <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         wb_q    <= wb_d;
         sov_q   <= sov_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
      end
   end
   assign ready_o    = state_q != SHIFT;
   assign busy_o     = state_q == SHIFT;
   assign done_o     = state_q == DONE;
   assign bcd_o      = bcd_q;
   assign overflow_o = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and randomized checks of bin2bcd_seq against an arithmetic model
module tb_bin2bcd_seq;
   import bin2bcd_pkg::*;
   localparam int NS = 12;
   localparam int WL [NS] = '{1, 1, 1, 7, 7, 7, 16, 16, 16, 32, 32, 32};
   localparam int DL [NS] = '{1, 3, digits_for_width(1), 1, 3, digits_for_width(7),
                              1, 3, digits_for_width(16), 1, 3, digits_for_width(32)};
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] value = '0;
   logic        ready, busy, done, ovf;
   logic [31:0] bcd;
   logic        sw_start = 1'b0;
   logic [31:0] sw_val = '0;
   logic [39:0] sw_bcd [NS];
   logic        sw_done [NS];
   logic        sw_ovf [NS];
   logic        sw_rdy [NS];
   logic        sw_bsy [NS];
   int          lat [NS];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.WIDTH(32), .DIGITS(8)) u_dut (
      .clk(clk), .rst(rst), .start_i(start), .value_i(value),
      .ready_o(ready), .busy_o(busy), .done_o(done), .bcd_o(bcd), .overflow_o(ovf)
   );

   for (genvar g = 0; g < NS; g++) begin : g_sw
      logic [4*DL[g]-1:0] b;
      bin2bcd_seq #(.WIDTH(WL[g]), .DIGITS(DL[g])) u_sw (
         .clk(clk), .rst(rst), .start_i(sw_start), .value_i(sw_val[WL[g]-1:0]),
         .ready_o(sw_rdy[g]), .busy_o(sw_bsy[g]), .done_o(sw_done[g]), .bcd_o(b),
         .overflow_o(sw_ovf[g])
      );
      assign sw_bcd[g] = 40'(b);
   end

   function automatic logic [39:0] ref_bcd(input longint unsigned v, input int d);
      logic [39:0] r = '0;
      longint unsigned m = v;
      for (int k = 0; k < d; k++) begin
         r[4*k +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   function automatic logic ref_ovf(input longint unsigned v, input int d);
      longint unsigned p = 1;
      for (int k = 0; k < d; k++) p = p * 10;
      return v >= p;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run(input logic [31:0] v);
      int n = 0;
      @(negedge clk);
      value = v;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      while (n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (done) break;
      end
      check($sformatf("latency(%0d)", v), 64'(n), 64'd32);
      check($sformatf("bcd(%0d)", v), 64'(bcd), 64'(ref_bcd(64'(v), 8)));
      check($sformatf("ovf(%0d)", v), 64'(ovf), 64'(ref_ovf(64'(v), 8)));
      check($sformatf("ready_at_done(%0d)", v), 64'(ready), 64'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, last, cnt;
      logic [31:0] sv;
      longint unsigned mv;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_bcd", 64'(bcd), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      rst = 1'b0;

      run(32'd12345678);
      run(32'd99999999);

      // reset mid-conversion clears outputs immediately
      @(negedge clk);
      value = 32'd100000000;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 check("mid_busy", 64'(busy), 64'd1);
      #1 rst = 1'b1;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_ready", 64'(ready), 64'd1);
      check("arst_done", 64'(done), 64'd0);
      check("arst_bcd", 64'(bcd), 64'd0);
      check("arst_ovf", 64'(ovf), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run(32'd4096);
      run(32'd100000000);
      run(32'hFFFFFFFF);
      run(32'd0);

      // start held high: one result every 33 cycles, value noise during SHIFT is ignored
      @(negedge clk);
      value = '0;
      start = 1'b1;
      c = 0;
      last = -1;
      cnt = 0;
      while (c < 300 && cnt < 4) begin
         @(posedge clk);
         c++;
         @(negedge clk);
         value = busy ? $urandom : 32'd0;
         if (done) begin
            if (last >= 0) check("b2b_period", 64'(c - last), 64'd33);
            check("b2b_bcd", 64'(bcd), 64'd0);
            check("b2b_ovf", 64'(ovf), 64'd0);
            last = c;
            cnt++;
         end
      end
      start = 1'b0;
      value = '0;
      check("b2b_count", 64'(cnt), 64'd4);

      // randomized sweep across widths and digit counts
      for (int it = 0; it < 24; it++) begin
         @(negedge clk);
         sv = (it == 0) ? 32'd0 : (it == 1) ? 32'hFFFFFFFF :
              ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 2000));
         sw_val = sv;
         sw_start = 1'b1;
         for (int g = 0; g < NS; g++) lat[g] = 0;
         @(posedge clk);
         #1 sw_start = 1'b0;
         sw_val = $urandom;
         for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            for (int g = 0; g < NS; g++) if (sw_done[g] && lat[g] == 0) lat[g] = n;
         end
         for (int g = 0; g < NS; g++) begin
            mv = 64'(sv) & ((64'd1 << WL[g]) - 64'd1);
            check($sformatf("sw%0d_lat(%0h)", g, mv), 64'(lat[g]), 64'(WL[g]));
            check($sformatf("sw%0d_bcd(%0h)", g, mv), 64'(sw_bcd[g]), 64'(ref_bcd(mv, DL[g])));
            check($sformatf("sw%0d_ovf(%0h)", g, mv), 64'(sw_ovf[g]), 64'(ref_ovf(mv, DL[g])));
            check($sformatf("sw%0d_idle", g), {62'd0, sw_rdy[g], sw_bsy[g]}, 64'd2);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
